// File: rtl/count_display_scanner_if.sv
// Counter-to-display bus: raw count in, multiplexed 7-segment drive and accepted value out.
// No handshake; count_in is free-running and asynchronous, all outputs are registered.
interface count_display_scanner_if;
   logic [3:0] count_in;
   logic [6:0] seg;
   logic [1:0] an;
   logic [3:0] value;
   logic       value_valid;

   modport master (output count_in, input seg, an, value, value_valid);
   modport slave  (input count_in, output seg, an, value, value_valid);
endinterface

// File: rtl/count_display_scanner.sv
// Debounces an async 4-bit count and scans it onto a 2-digit 7-seg display; DISP_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
// Latency: value on the (2+STABLE_CYCLES)th edge after count_in settles; seg/an lag the scan state by one cycle.
// Backpressure: none; input is sampled every cycle and the display free-runs.
module count_display_scanner #(
   parameter int REFRESH_DIV    = 1024,
   parameter int STABLE_CYCLES  = 3,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                          clk,
   input  logic                          clr,
   count_display_scanner_if.slave        bus
);
   localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
   localparam logic [6:0]    SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   typedef enum logic [1:0] {GAP_T, UNITS, GAP_U, TENS} state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    value_q, value_d;
   logic          value_valid_q, value_valid_d;
   logic [1:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;

   logic          tens;
   logic [3:0]    units;
   logic [6:0]    units_seg, tens_seg;

   function automatic logic [6:0] digit_seg(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h00;
      endcase
      return SEG_ACTIVE_LOW ? ~p : p;
   endfunction

   // Stability filter: a sample is only trusted after CNT_MAX equal synchronized samples.
   always_comb begin
      sync1_d       = bus.count_in;
      sync2_d       = sync1_q;
      prev_d        = sync2_q;
      value_d       = value_q;
      value_valid_d = 1'b0;
      if (sync2_q != prev_q)
         cnt_d = CW'(1);
      else if (cnt_q == CNT_MAX)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + 1'b1;
      if (cnt_d >= CNT_MAX && sync2_q != value_q) begin
         value_d       = sync2_q;
         value_valid_d = 1'b1;
      end
   end

   always_comb begin
      tens      = (value_q >= 4'd10);
      units     = tens ? (value_q - 4'd10) : value_q;
      units_seg = digit_seg(units);
      tens_seg  = digit_seg({3'b000, tens});
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      an_d    = 2'b11;
      seg_d   = SEG_OFF;
      case (state_q)
         GAP_T: begin
            state_d = UNITS;
            div_d   = '0;
         end
         UNITS: begin
            an_d  = 2'b10;
            seg_d = units_seg;
            if (div_q == DIV_LAST) begin
               state_d = GAP_U;
               div_d   = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         GAP_U: begin
            state_d = TENS;
            div_d   = '0;
         end
         TENS: begin
            an_d  = 2'b01;
            seg_d = tens_seg;
`ifdef DISP_LEADING_ZERO_BLANK_EN
            if (!tens) begin
               an_d  = 2'b11;
               seg_d = SEG_OFF;
            end
`endif
            if (div_q == DIV_LAST) begin
               state_d = GAP_T;
               div_d   = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: begin
            state_d = GAP_T;
            div_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q       <= GAP_T;
         div_q         <= '0;
         sync1_q       <= '0;
         sync2_q       <= '0;
         prev_q        <= '0;
         cnt_q         <= '0;
         value_q       <= '0;
         value_valid_q <= 1'b0;
         an_q          <= 2'b11;
         seg_q         <= SEG_OFF;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         prev_q        <= prev_d;
         cnt_q         <= cnt_d;
         value_q       <= value_d;
         value_valid_q <= value_valid_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.an          = an_q;
   assign bus.value       = value_q;
   assign bus.value_valid = value_valid_q;
endmodule

// File: tb/tb_count_display_scanner.sv
// Directed bench for count_display_scanner with REFRESH_DIV=4, STABLE_CYCLES=3, active-low segments.
module tb_count_display_scanner;
   logic clk = 1'b0;
   logic clr = 1'b0;
   int   total = 0;
   int   bad   = 0;

   count_display_scanner_if bus();

   count_display_scanner #(
      .REFRESH_DIV   (4),
      .STABLE_CYCLES (3),
      .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, leaving time 1ns past the last one.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      bus.count_in = 4'h9;
      tick(3);
      chk("rst_an", {6'd0, bus.an}, 8'h03);
      chk("rst_seg", {1'b0, bus.seg}, 8'h7F);
      chk("rst_value", {4'd0, bus.value}, 8'h00);
      chk("rst_vld", {7'd0, bus.value_valid}, 8'h00);

      // Release reset with count 7; edges below are numbered from the release.
      clr = 1'b1;
      bus.count_in = 4'd7;
      tick(1);  // e1
      chk("rel_e1_an", {6'd0, bus.an}, 8'h03);
      tick(1);  // e2
      chk("rel_e2_an", {6'd0, bus.an}, 8'h02);
      chk("rel_e2_seg", {1'b0, bus.seg}, 8'h40);
      tick(2);  // e4
      chk("pre7_value", {4'd0, bus.value}, 8'h00);
      chk("pre7_vld", {7'd0, bus.value_valid}, 8'h00);
      tick(1);  // e5
      chk("acc7_value", {4'd0, bus.value}, 8'h07);
      chk("acc7_vld", {7'd0, bus.value_valid}, 8'h01);
      tick(1);  // e6
      chk("acc7_vld_end", {7'd0, bus.value_valid}, 8'h00);
      chk("gapu_an", {6'd0, bus.an}, 8'h03);
      chk("gapu_seg", {1'b0, bus.seg}, 8'h7F);
      tick(1);  // e7
      chk("t7_an", {6'd0, bus.an}, 8'h01);
      chk("t7_seg", {1'b0, bus.seg}, 8'h40);
      tick(5);  // e12
      chk("u7_an", {6'd0, bus.an}, 8'h02);
      chk("u7_seg", {1'b0, bus.seg}, 8'h78);

      // One-cycle glitch to 5 must be discarded.
      bus.count_in = 4'd5;
      tick(1);  // e13
      bus.count_in = 4'd7;
      for (int i = 0; i < 8; i++) begin  // e14..e21
         tick(1);
         chk("glitch_value", {4'd0, bus.value}, 8'h07);
         chk("glitch_vld", {7'd0, bus.value_valid}, 8'h00);
      end

      // 13 settles before e22, accepted on e26.
      bus.count_in = 4'd13;
      tick(4);  // e25
      chk("pre13_value", {4'd0, bus.value}, 8'h07);
      tick(1);  // e26
      chk("acc13_value", {4'd0, bus.value}, 8'h0D);
      chk("acc13_vld", {7'd0, bus.value_valid}, 8'h01);
      chk("gap13_an", {6'd0, bus.an}, 8'h03);
      chk("gap13_seg", {1'b0, bus.seg}, 8'h7F);
      tick(1);  // e27
      chk("t13_an", {6'd0, bus.an}, 8'h01);
      chk("t13_seg", {1'b0, bus.seg}, 8'h79);
      chk("acc13_vld_end", {7'd0, bus.value_valid}, 8'h00);
      tick(4);  // e31
      chk("gapt13_an", {6'd0, bus.an}, 8'h03);
      chk("gapt13_seg", {1'b0, bus.seg}, 8'h7F);
      tick(1);  // e32
      chk("u13_an", {6'd0, bus.an}, 8'h02);
      chk("u13_seg", {1'b0, bus.seg}, 8'h30);

      // 15 then wrap to 0.
      bus.count_in = 4'd15;
      tick(5);  // e37
      chk("acc15_value", {4'd0, bus.value}, 8'h0F);
      chk("acc15_vld", {7'd0, bus.value_valid}, 8'h01);
      bus.count_in = 4'd0;
      tick(4);  // e41
      chk("prewrap_value", {4'd0, bus.value}, 8'h0F);
      chk("prewrap_vld", {7'd0, bus.value_valid}, 8'h00);
      tick(1);  // e42
      chk("wrap_value", {4'd0, bus.value}, 8'h00);
      chk("wrap_vld", {7'd0, bus.value_valid}, 8'h01);
      tick(1);  // e43
      chk("wrap_vld_end", {7'd0, bus.value_valid}, 8'h00);
      chk("u0_seg", {1'b0, bus.seg}, 8'h40);
      tick(3);  // e46
      for (int i = 0; i < 4; i++) begin  // e47..e50
         tick(1);
`ifdef DISP_LEADING_ZERO_BLANK_EN
         chk("t0_an", {6'd0, bus.an}, 8'h03);
         chk("t0_seg", {1'b0, bus.seg}, 8'h7F);
`else
         chk("t0_an", {6'd0, bus.an}, 8'h01);
         chk("t0_seg", {1'b0, bus.seg}, 8'h40);
`endif
      end

      // Back to 13, then reset in the middle of the tens slot.
      bus.count_in = 4'd13;
      tick(5);  // e55
      chk("re13_value", {4'd0, bus.value}, 8'h0D);
      tick(2);  // e57
      chk("mid_t_an", {6'd0, bus.an}, 8'h01);
      chk("mid_t_seg", {1'b0, bus.seg}, 8'h79);
      tick(1);  // e58
      clr = 1'b0;
      #1;
      chk("arst_an", {6'd0, bus.an}, 8'h03);
      chk("arst_seg", {1'b0, bus.seg}, 8'h7F);
      chk("arst_value", {4'd0, bus.value}, 8'h00);
      chk("arst_vld", {7'd0, bus.value_valid}, 8'h00);
      tick(2);
      clr = 1'b1;
      tick(1);
      chk("resume_e1_an", {6'd0, bus.an}, 8'h03);
      tick(1);
      chk("resume_e2_an", {6'd0, bus.an}, 8'h02);
      chk("resume_e2_seg", {1'b0, bus.seg}, 8'h40);
      tick(3);
      chk("resume_value", {4'd0, bus.value}, 8'h0D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
